// File: rtl/downstream_cancel_processor.sv
`timescale 1ns/1ps
// downstream_cancel_processor: applies exchange cancel notifications to the client record RAM
// by read-modify-write, saturating accumulated_orders at zero and reporting the result.
module downstream_cancel_processor #(
    parameter int ID_W           = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            HRESETn,
    input  logic            cancel_valid,
    output logic            cancel_ready,
    input  logic [ID_W-1:0] cancel_client_id,
    input  logic [15:0]     cancel_amount,
    output logic            mem_req_valid,
    output logic            mem_req_rw,
    output logic [ID_W-1:0] mem_req_index,
    output logic [31:0]     mem_req_data,
    input  logic            mem_res_ready,
    input  logic [31:0]     mem_res_data,
    output logic            ack_valid,
    output logic [ID_W-1:0] ack_client_id,
    output logic [15:0]     ack_accumulated,
    output logic            ack_underflow,
    output logic            ack_error,
    output logic            busy,
    output logic [15:0]     cancels_done
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d, ack_id_q, ack_id_d;
    logic [15:0]     amt_q, amt_d, hi_q, hi_d, acc_q, acc_d, ack_acc_q, ack_acc_d;
    logic [15:0]     cancels_done_q, cancels_done_d;
    logic            und_q, und_d, ack_und_q, ack_und_d, ack_err_q, ack_err_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            timed_out;

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        amt_d          = amt_q;
        hi_d           = hi_q;
        acc_d          = acc_q;
        und_d          = und_q;
        wait_d         = wait_q;
        ack_id_d       = ack_id_q;
        ack_acc_d      = ack_acc_q;
        ack_und_d      = ack_und_q;
        ack_err_d      = ack_err_q;
        cancels_done_d = cancels_done_q;
        timed_out      = !mem_res_ready && (wait_q == CW'(TIMEOUT_CYCLES - 1));
        case (state_q)
            IDLE: if (cancel_valid) begin
                id_d    = cancel_client_id;
                amt_d   = cancel_amount;
                wait_d  = '0;
                state_d = RD;
            end
            RD: if (mem_res_ready) begin
                hi_d    = mem_res_data[31:16];
                und_d   = amt_q > mem_res_data[15:0];
                acc_d   = und_d ? 16'd0 : mem_res_data[15:0] - amt_q;
                wait_d  = '0;
                state_d = WR;
            end else if (!timed_out) begin
                wait_d = wait_q + CW'(1);
            end
            WR: if (mem_res_ready) begin
                cancels_done_d = cancels_done_q + 16'd1;
                ack_id_d       = id_q;
                ack_acc_d      = acc_q;
                ack_und_d      = und_q;
                ack_err_d      = 1'b0;
                state_d        = ACK;
            end else if (!timed_out) begin
                wait_d = wait_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        // A stalled RAM aborts the transaction: report an error without touching the counter.
        if ((state_q == RD || state_q == WR) && timed_out) begin
            ack_id_d  = id_q;
            ack_acc_d = 16'd0;
            ack_und_d = 1'b0;
            ack_err_d = 1'b1;
            state_d   = ACK;
        end
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q        <= IDLE;
            id_q           <= '0;
            amt_q          <= '0;
            hi_q           <= '0;
            acc_q          <= '0;
            und_q          <= 1'b0;
            wait_q         <= '0;
            ack_id_q       <= '0;
            ack_acc_q      <= '0;
            ack_und_q      <= 1'b0;
            ack_err_q      <= 1'b0;
            cancels_done_q <= '0;
        end else begin
            state_q        <= state_d;
            id_q           <= id_d;
            amt_q          <= amt_d;
            hi_q           <= hi_d;
            acc_q          <= acc_d;
            und_q          <= und_d;
            wait_q         <= wait_d;
            ack_id_q       <= ack_id_d;
            ack_acc_q      <= ack_acc_d;
            ack_und_q      <= ack_und_d;
            ack_err_q      <= ack_err_d;
            cancels_done_q <= cancels_done_d;
        end
    end

    assign cancel_ready    = state_q == IDLE;
    assign mem_req_valid   = state_q == RD || state_q == WR;
    assign mem_req_rw      = state_q == WR;
    assign mem_req_index   = id_q;
    assign mem_req_data    = {hi_q, acc_q};
    assign ack_valid       = state_q == ACK;
    assign ack_client_id   = ack_id_q;
    assign ack_accumulated = ack_acc_q;
    assign ack_underflow   = ack_und_q;
    assign ack_error       = ack_err_q;
    assign busy            = state_q != IDLE;
    assign cancels_done    = cancels_done_q;

    a_onehot_rw: assert property (@(posedge clk) disable iff (!HRESETn)
        $onehot0({state_q == RD, state_q == WR}));
    a_req_busy: assert property (@(posedge clk) disable iff (!HRESETn)
        mem_req_valid |-> busy);
    a_req_stable: assert property (@(posedge clk) disable iff (!HRESETn)
        mem_req_valid && !mem_res_ready |=> !mem_req_valid || $stable({mem_req_rw, mem_req_index, mem_req_data}));
    a_ack_pulse: assert property (@(posedge clk) disable iff (!HRESETn)
        ack_valid |=> !ack_valid);
endmodule

// File: tb/tb_downstream_cancel_processor.sv
`timescale 1ns/1ps
// tb_downstream_cancel_processor: directed cancels against a behavioural RAM; expected acks and
// writes are queued at issue and checked by independent monitors.
module tb_downstream_cancel_processor;
    logic        clk = 1'b0;
    logic        HRESETn;
    logic        cancel_valid, cancel_ready;
    logic [4:0]  cancel_client_id;
    logic [15:0] cancel_amount;
    logic        mem_req_valid, mem_req_rw;
    logic [4:0]  mem_req_index;
    logic [31:0] mem_req_data;
    logic        mem_res_ready;
    logic [31:0] mem_res_data;
    logic        ack_valid;
    logic [4:0]  ack_client_id;
    logic [15:0] ack_accumulated;
    logic        ack_underflow, ack_error, busy;
    logic [15:0] cancels_done;

    downstream_cancel_processor dut (
        .clk(clk), .HRESETn(HRESETn),
        .cancel_valid(cancel_valid), .cancel_ready(cancel_ready),
        .cancel_client_id(cancel_client_id), .cancel_amount(cancel_amount),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
        .mem_req_index(mem_req_index), .mem_req_data(mem_req_data),
        .mem_res_ready(mem_res_ready), .mem_res_data(mem_res_data),
        .ack_valid(ack_valid), .ack_client_id(ack_client_id),
        .ack_accumulated(ack_accumulated), .ack_underflow(ack_underflow),
        .ack_error(ack_error), .busy(busy), .cancels_done(cancels_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] id; logic [15:0] acc; logic und; logic err; int cyc; } ack_t;
    typedef struct { logic [4:0] idx; logic [31:0] data; } wr_t;

    ack_t        exp_ack[$];
    wr_t         exp_wr[$];
    logic [31:0] mem[32];
    int          cyc = 0, passed = 0, total = 0;
    int          rd_delay = 0, wr_delay = 0, wcnt = 0;
    bit          ram_hold = 0, stray = 0, pv = 0;
    logic [37:0] prev;
    logic [15:0] exp_done = 0;
    int          c1, c2, cx, n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic send(input logic [4:0] id, input logic [15:0] amt, input logic [15:0] e_acc,
                        input logic e_und, input logic e_err, input logic [31:0] e_wr,
                        input bit do_wr, input int lat, output int acc_cyc);
        int k = 0;
        ack_t a;
        wr_t w;
        cancel_valid = 1'b1;
        cancel_client_id = id;
        cancel_amount = amt;
        while (!cancel_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!cancel_ready) chk("accept_bound", {63'd0, cancel_ready}, 64'd1);
        acc_cyc = cyc;
        if (lat > 0) begin
            a.id = id; a.acc = e_acc; a.und = e_und; a.err = e_err; a.cyc = acc_cyc + lat;
            exp_ack.push_back(a);
        end
        if (do_wr) begin
            w.idx = id; w.data = e_wr;
            exp_wr.push_back(w);
        end
        @(negedge clk);
        cancel_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || exp_ack.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("pending_acks", 64'(exp_ack.size()), 64'd0);
    endtask

    // Behavioural RAM responder; also checks request stability across wait states.
    initial begin
        wr_t w;
        mem_res_ready = 1'b0;
        mem_res_data = '0;
        forever begin
            @(negedge clk);
            if (HRESETn && pv && mem_req_valid)
                chk("req_stable", {26'd0, mem_req_rw, mem_req_index, mem_req_data}, {26'd0, prev});
            mem_res_ready = 1'b0;
            if (!HRESETn || !mem_req_valid) begin
                wcnt = 0;
                mem_res_ready = stray;
            end else if (!ram_hold) begin
                if (wcnt < (mem_req_rw ? wr_delay : rd_delay)) wcnt++;
                else begin
                    wcnt = 0;
                    mem_res_ready = 1'b1;
                    mem_res_data = mem[mem_req_index];
                    if (mem_req_rw) begin
                        if (exp_wr.size() == 0) chk("unexpected_write", {27'd0, mem_req_index, mem_req_data}, 64'd0);
                        else begin
                            w = exp_wr.pop_front();
                            chk("write", {27'd0, mem_req_index, mem_req_data}, {27'd0, w.idx, w.data});
                        end
                        mem[mem_req_index] = mem_req_data;
                    end
                end
            end
            pv = HRESETn && mem_req_valid && !mem_res_ready;
            prev = {mem_req_rw, mem_req_index, mem_req_data};
        end
    end

    initial begin
        ack_t e;
        forever begin
            @(negedge clk);
            if (ack_valid) begin
                if (exp_ack.size() == 0) chk("unexpected_ack", {41'd0, ack_client_id, ack_accumulated, 1'b1}, 64'd0);
                else begin
                    e = exp_ack.pop_front();
                    chk("ack_fields", {45'd0, ack_client_id, ack_accumulated, ack_underflow, ack_error},
                        {45'd0, e.id, e.acc, e.und, e.err});
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        HRESETn = 1'b0;
        cancel_valid = 1'b0;
        cancel_client_id = '0;
        cancel_amount = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, cancel_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_req", {63'd0, mem_req_valid}, 64'd0);
        chk("rst_ack", {45'd0, ack_valid, ack_client_id, ack_accumulated, ack_underflow, ack_error}, 64'd0);
        chk("rst_done", {48'd0, cancels_done}, 64'd0);
        HRESETn = 1'b1;
        @(negedge clk);

        // Reset while the write is stalled: no ack, no write, record intact.
        mem[9] = 32'h0003_0009;
        wr_delay = 3;
        send(5'd9, 16'd1, 16'd0, 1'b0, 1'b0, 32'd0, 1'b0, -1, cx);
        n = 0;
        while (!(mem_req_valid && mem_req_rw) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reached_wr", {63'd0, mem_req_rw}, 64'd1);
        HRESETn = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_req", {63'd0, mem_req_valid}, 64'd0);
        chk("midrst_ready", {63'd0, cancel_ready}, 64'd1);
        chk("midrst_done", {48'd0, cancels_done}, 64'd0);
        repeat (2) @(negedge clk);
        HRESETn = 1'b1;
        wr_delay = 0;
        repeat (3) @(negedge clk);
        chk("midrst_mem", {32'd0, mem[9]}, 64'h0003_0009);

        mem[3] = 32'h0064_0028;
        send(5'd3, 16'd15, 16'h0019, 1'b0, 1'b0, 32'h0064_0019, 1'b1, 3, cx);
        wait_idle();
        exp_done = 1;
        chk("done_normal", {48'd0, cancels_done}, {48'd0, exp_done});

        mem[7] = 32'h0032_000A;
        send(5'd7, 16'd20, 16'h0000, 1'b1, 1'b0, 32'h0032_0000, 1'b1, 3, cx);
        wait_idle();
        mem[12] = 32'h1234_5678;
        send(5'd12, 16'd0, 16'h5678, 1'b0, 1'b0, 32'h1234_5678, 1'b1, 3, cx);
        wait_idle();
        mem[13] = 32'h0005_0005;
        send(5'd13, 16'd5, 16'h0000, 1'b0, 1'b0, 32'h0005_0000, 1'b1, 3, cx);
        wait_idle();
        exp_done = 4;
        chk("done_edges", {48'd0, cancels_done}, {48'd0, exp_done});

        mem[20] = 32'hABCD_0100;
        rd_delay = 5;
        wr_delay = 2;
        send(5'd20, 16'h0010, 16'h00F0, 1'b0, 1'b0, 32'hABCD_00F0, 1'b1, 10, cx);
        wait_idle();
        rd_delay = 0;
        wr_delay = 0;
        exp_done = 5;

        // Stray RAM responses while idle must be ignored.
        stray = 1;
        repeat (4) @(negedge clk);
        chk("stray_busy", {63'd0, busy}, 64'd0);
        stray = 0;
        chk("stray_done", {48'd0, cancels_done}, {48'd0, exp_done});

        mem[4] = 32'h0009_0009;
        ram_hold = 1;
        send(5'd4, 16'd1, 16'h0000, 1'b0, 1'b1, 32'd0, 1'b0, 17, cx);
        n = 0;
        while (!ack_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("to_ready", {63'd0, cancel_ready}, 64'd1);
        ram_hold = 0;
        chk("to_done", {48'd0, cancels_done}, {48'd0, exp_done});
        chk("to_mem", {32'd0, mem[4]}, 64'h0009_0009);

        mem[1] = 32'h0010_0020;
        mem[2] = 32'h0008_0007;
        send(5'd1, 16'd5, 16'h001B, 1'b0, 1'b0, 32'h0010_001B, 1'b1, 3, c1);
        send(5'd2, 16'd7, 16'h0000, 1'b0, 1'b0, 32'h0008_0000, 1'b1, 3, c2);
        wait_idle();
        chk("b2b_gap", 64'(c2 - c1), 64'd4);
        exp_done = 7;
        chk("b2b_done", {48'd0, cancels_done}, {48'd0, exp_done});

        force dut.cancels_done_q = 16'hFFFF;
        @(negedge clk);
        release dut.cancels_done_q;
        @(negedge clk);
        chk("preload", {48'd0, cancels_done}, 64'hFFFF);
        mem[5] = 32'h0001_0001;
        send(5'd5, 16'd1, 16'h0000, 1'b0, 1'b0, 32'h0001_0000, 1'b1, 3, cx);
        wait_idle();
        chk("wrap", {48'd0, cancels_done}, 64'd0);

        repeat (3) @(negedge clk);
        chk("writes_left", 64'(exp_wr.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/downstream_cancel_processor.md
Name: downstream_cancel_processor

Overview:
- Return-path counterpart of the upstream order processor. It accepts cancel/fill-back notifications from the exchange side and performs a read-modify-write on the shared per-client record RAM.
- It subtracts the cancelled amount from the client's accumulated_orders and leaves max_to_trade untouched, then reports the updated exposure.
- It acts as initiator on the client-record RAM port. Arbitration against the upstream processor is done outside this block.

Parameters:
- ID_W, 5, client index width (32 clients)
- TIMEOUT_CYCLES, 16, maximum cycles to wait for mem_res_ready before aborting; must be >= 1

Ports:
- clk  in  1  system clock, all state on rising edge
- HRESETn  in  1  asynchronous active-low reset
- cancel_valid  in  1  notification present
- cancel_ready  out  1  block can accept a notification
- cancel_client_id  in  ID_W  client index
- cancel_amount  in  16  unsigned amount cancelled
- mem_req_valid  out  1  RAM request pending
- mem_req_rw  out  1  0=read, 1=write
- mem_req_index  out  ID_W  record index
- mem_req_data  out  32  write data, {max_to_trade[15:0], accumulated_orders[15:0]}
- mem_res_ready  in  1  read data valid / write complete
- mem_res_data  in  32  read data, same packing as mem_req_data
- ack_valid  out  1  one-cycle completion pulse
- ack_client_id  out  ID_W  client of completed notification
- ack_accumulated  out  16  accumulated_orders after update
- ack_underflow  out  1  subtraction saturated
- ack_error  out  1  RAM timeout, no write performed
- busy  out  1  state != IDLE
- cancels_done  out  16  count of successful updates, wraps at 0xFFFF->0

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0 except cancel_ready=1; counters 0; captured fields 0.
- FSM states: IDLE, RD, WR, ACK.
- IDLE:
  - cancel_ready=1.
  - On cancel_valid&&cancel_ready, capture id and amount; next state RD.
- RD:
  - mem_req_valid=1, rw=0, index=captured id. These fields stay stable until completion.
  - On a cycle with mem_res_ready=1, latch mem_res_data and compute:
    - new_acc = (acc >= amount) ? acc - amount : 0
    - underflow = (amount > acc)
  - Next state WR.
- WR:
  - mem_req_valid=1, rw=1, data={latched[31:16], new_acc}. Stable until mem_res_ready=1.
  - On mem_res_ready, increment cancels_done; next state ACK.
- ACK:
  - ack_valid=1 for exactly one cycle, together with ack_client_id, ack_accumulated, ack_underflow and ack_error.
  - Next state IDLE. ack_* fields hold their value until the next ACK.
- cancel_ready=0 in RD, WR and ACK. There is no buffering; the upstream side must hold cancel_valid and its fields until accepted.
- mem_req_valid=0 in IDLE and ACK.
- Latency: minimum 3 cycles from the accept edge to the ack_valid cycle (mem_res_ready high on the first cycle of both RD and WR). Back-to-back notifications are accepted at most every 4 cycles.
- Timeout:
  - The wait counter resets on entry to RD and to WR, and increments each cycle mem_res_ready=0.
  - When it reaches TIMEOUT_CYCLES, abort: drop mem_req_valid, skip the write, go to ACK with ack_error=1, ack_accumulated=0, ack_underflow=0. cancels_done is unchanged.
- cancel_amount=0: full read-modify-write still performed (record rewritten unchanged); underflow=0.
- Underflow saturates at 0; never wraps negative.
- max_to_trade bits [31:16] are written back exactly as read.
- mem_res_ready while in IDLE or ACK is ignored.
- Reset mid-operation: the transaction is abandoned, with no ack and no write completion, and the FSM returns to IDLE. Any RAM transfer already completed is not reverted.
- Assertions:
  - At most one of (RD, WR) active; mem_req_valid implies busy.
  - mem_req fields stable while valid and not ready.
  - ack_valid never high two consecutive cycles.

Test Plan:
- Reset: HRESETn low mid-WR -> next cycle state IDLE, mem_req_valid=0, cancel_ready=1, ack_valid never pulses, cancels_done=0.
- Normal: record[3]=0x0064_0028 (max 100, acc 40), cancel id=3 amount=15, RAM ready immediate -> write 0x0064_0019; ack 3 cycles after accept with acc=25, underflow=0, error=0; cancels_done=1.
- Underflow: record[7]=0x0032_000A, cancel amount=20 -> write 0x0032_0000; ack_accumulated=0, ack_underflow=1.
- Wait states: mem_res_ready delayed 5 cycles on read and 2 on write -> request fields stable throughout; ack at accept+10.
- Timeout: TIMEOUT_CYCLES=16, mem_res_ready held 0 -> after 16 RD cycles ack_error=1, no write request, cancels_done unchanged, cancel_ready=1 next cycle.
- Back-to-back: two notifications offered continuously (id 1 amount 5, then id 2 amount 7) -> second accepted exactly 4 cycles after the first; two acks in order; cancels_done=2; wrap check by preloading 0xFFFF -> 0.
